// File: rtl/reduce_accum.sv
// reduce_accum
//   Runs one bit-reduction job over a stream of N-bit words. A job is
//   launched from IDLE with `start`. It then accepts `len` words in ACCUM.
//   Each word is first reduced to one bit (&, | or ^ over the word). That
//   bit is folded into a single-bit accumulator with the selected operation.
//   The 1-bit result is then held in DONE until the consumer takes it.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start, clear        launch a job (IDLE only) / synchronous abort
//   mode[1:0], len      00 AND, 01 OR, 10 XOR, 11 NAND; word count
//                       (both captured with start)
//   in_valid, in_data   input word stream
//   in_ready            high in ACCUM
//   out_valid, out_data result, held until out_ready
//   out_ready           consumer accepts the result
//   busy                state is not IDLE
//   words_done          words accepted in the current job
//   state_dbg           current FSM state (0 IDLE, 1 ACCUM, 2 DONE)
//
// Handshake rule for both streams: a beat transfers on the rising edge
// where valid and ready are both high. The producer keeps its data stable
// while valid is high and ready is low.
module reduce_accum #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [N-1:0]     in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic             out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] words_done,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0]       MODE_AND  = 2'b00;
  localparam logic [1:0]       MODE_OR   = 2'b01;
  localparam logic [1:0]       MODE_XOR  = 2'b10;
  localparam logic [1:0]       MODE_NAND = 2'b11;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] words_done_q, words_done_d;
  logic [CNT_W-1:0] count_inc;
  logic             ident;

  // AND and NAND start from 1. OR and XOR start from 0.
  always_comb begin
    ident = 1'b0;
    case (mode)
      MODE_AND, MODE_NAND: ident = 1'b1;
      default:             ident = 1'b0;
    endcase
  end

  assign count_inc = words_done_q + CNT_ONE;

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    len_d        = len_q;
    acc_d        = acc_q;
    words_done_d = words_done_q;
    if (clear) begin
      // Abort wins over start, any transfer and the output handshake.
      state_d      = S_IDLE;
      acc_d        = 1'b0;
      words_done_d = CNT_ZERO;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_d       = mode;
            len_d        = len;
            acc_d        = ident;
            words_done_d = CNT_ZERO;
            state_d      = (len == CNT_ZERO) ? S_DONE : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            case (mode_q)
              MODE_OR:  acc_d = acc_q | (|in_data);
              MODE_XOR: acc_d = acc_q ^ (^in_data);
              default:  acc_d = acc_q & (&in_data);
            endcase
            words_done_d = count_inc;
            if (count_inc == len_q) state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mode_q       <= MODE_AND;
      len_q        <= CNT_ZERO;
      acc_q        <= 1'b0;
      words_done_q <= CNT_ZERO;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      len_q        <= len_d;
      acc_q        <= acc_d;
      words_done_q <= words_done_d;
    end
  end

  assign in_ready   = (state_q == S_ACCUM);
  assign out_valid  = (state_q == S_DONE);
  // Gated by DONE so the output reads 0 during reset and between jobs.
  assign out_data   = out_valid & ((mode_q == MODE_NAND) ? ~acc_q : acc_q);
  assign busy       = (state_q != S_IDLE);
  assign words_done = words_done_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_reduce_accum.sv
// tb_reduce_accum
//   Directed stimulus for reduce_accum (N=8, CNT_W=4). Every expected value
//   is hand-computed from the reduction rules.
module tb_reduce_accum;

  localparam int N     = 8;
  localparam int CNT_W = 4;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             clear;
  logic [1:0]       mode;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic [N-1:0]     in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_data;
  logic             out_ready;
  logic             busy;
  logic [CNT_W-1:0] words_done;
  logic [1:0]       state_dbg;

  int checks = 0;
  int errors = 0;

  reduce_accum #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .clear     (clear),
    .mode      (mode),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .words_done(words_done),
    .state_dbg (state_dbg)
  );

  // clock block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic start_job(input logic [1:0] m, input logic [CNT_W-1:0] l);
    start = 1'b1;
    mode  = m;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [N-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic take_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_valid"}, out_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; mode = 2'b00; len = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // reset state
    tick(); tick();
    check("rst_state", state_dbg, ST_IDLE);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_words_done", words_done, 0);
    rst_n = 1'b1;

    // AND, len 3, FF FF FF back to back; start taken on first edge after reset
    start_job(2'b00, 4'd3);
    check("and1_state", state_dbg, ST_ACCUM);
    check("and1_in_ready", in_ready, 1);
    check("and1_wd0", words_done, 0);
    send_word(8'hFF);
    send_word(8'hFF);
    check("and1_no_early_valid", out_valid, 0);
    check("and1_wd2", words_done, 2);
    send_word(8'hFF);
    check("and1_out_valid", out_valid, 1);
    check("and1_out_data", out_data, 1);
    check("and1_wd3", words_done, 3);
    check("and1_in_ready_done", in_ready, 0);
    take_result("and1");

    // AND, len 3, FF FE FF -> 0
    start_job(2'b00, 4'd3);
    check("and2_wd_reset", words_done, 0);
    send_word(8'hFF);
    send_word(8'hFE);
    send_word(8'hFF);
    check("and2_out_valid", out_valid, 1);
    check("and2_out_data", out_data, 0);
    take_result("and2");

    // OR, len 2, 00 00 -> 0
    start_job(2'b01, 4'd2);
    send_word(8'h00);
    send_word(8'h00);
    check("or1_out_valid", out_valid, 1);
    check("or1_out_data", out_data, 0);
    take_result("or1");

    // OR, len 2, 00 10 -> 1, then 5 cycles of backpressure with start pulsed
    start_job(2'b01, 4'd2);
    send_word(8'h00);
    send_word(8'h10);
    check("or2_out_data", out_data, 1);
    start = 1'b1; mode = 2'b00; len = 4'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", out_data, 1);
      check("bp_wd_held", words_done, 2);
    end
    start = 1'b0;
    take_result("bp");

    // XOR, len 2, 07 then 3 idle cycles then 01 -> 0. mode/len change mid-job.
    start_job(2'b10, 4'd2);
    send_word(8'h07);
    mode = 2'b00; len = 4'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("xor_gap_in_ready", in_ready, 1);
      check("xor_gap_wd", words_done, 1);
      check("xor_gap_valid", out_valid, 0);
    end
    send_word(8'h01);
    check("xor_out_valid", out_valid, 1);
    check("xor_out_data", out_data, 0);
    check("xor_wd", words_done, 2);
    take_result("xor");

    // NAND, len 0 -> DONE one cycle after start, result ~1 = 0
    start_job(2'b11, 4'd0);
    check("nand0_state", state_dbg, ST_DONE);
    check("nand0_out_valid", out_valid, 1);
    check("nand0_out_data", out_data, 0);
    check("nand0_wd", words_done, 0);
    take_result("nand0");

    // NAND, len 1, word 7F -> ~(1 & 0) = 1
    start_job(2'b11, 4'd1);
    send_word(8'h7F);
    check("nand1_out_data", out_data, 1);
    take_result("nand1");

    // OR, len 15 (maximum): 14 zero words then 01 -> 1, no counter wrap
    start_job(2'b01, 4'd15);
    for (int i = 0; i < 14; i++) send_word(8'h00);
    check("max_no_early_valid", out_valid, 0);
    check("max_wd14", words_done, 14);
    send_word(8'h01);
    check("max_out_valid", out_valid, 1);
    check("max_out_data", out_data, 1);
    check("max_wd15", words_done, 15);
    take_result("max");

    // clear after 1 of 3 words, with a transfer and start in the same cycle
    start_job(2'b00, 4'd3);
    send_word(8'hFF);
    clear = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    tick();
    clear = 1'b0; start = 1'b0; in_valid = 1'b0;
    check("clr_state", state_dbg, ST_IDLE);
    check("clr_busy", busy, 0);
    check("clr_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("clr_no_valid", out_valid, 0);
    end
    start_job(2'b00, 4'd3);
    send_word(8'hFF);
    send_word(8'hFF);
    send_word(8'hFF);
    check("clr_next_valid", out_valid, 1);
    check("clr_next_data", out_data, 1);
    take_result("clr_next");

    // clear while DONE with out_ready high also lands in IDLE
    start_job(2'b01, 4'd0);
    clear = 1'b1; out_ready = 1'b1;
    tick();
    clear = 1'b0; out_ready = 1'b0;
    check("clr_done_state", state_dbg, ST_IDLE);

    // asynchronous reset after 1 of 3 words
    start_job(2'b00, 4'd3);
    send_word(8'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_state", state_dbg, ST_IDLE);
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_wd", words_done, 0);
    check("arst_valid", out_valid, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("arst_no_valid", out_valid, 0);
    end
    start_job(2'b10, 4'd1);
    send_word(8'h80);
    check("arst_next_valid", out_valid, 1);
    check("arst_next_data", out_data, 1);
    check("arst_next_wd", words_done, 1);
    take_result("arst_next");

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
